// File: rtl/fb_burst_reader.sv
// Frame-buffer burst reader: fetches a frame from DDR over Avalon-MM bursts
// and streams it out of a show-ahead pixel FIFO, issuing bursts only when credit allows.
module fb_burst_reader #(
    parameter int BURST_LEN   = 64,
    parameter int FIFO_DEPTH  = 512,
    parameter int FRAME_WORDS = 384000
) (
    input  logic        clk_clk,
    input  logic        reset_reset,
    input  logic [29:0] start_address,
    input  logic        frame_start,
    output logic [29:0] ddr_address,
    output logic [7:0]  ddr_burstcount,
    output logic        ddr_read,
    input  logic        ddr_waitrequest,
    input  logic [31:0] ddr_readdata,
    input  logic        ddr_readdatavalid,
    output logic [31:0] pix_data,
    output logic        pix_valid,
    input  logic        pix_ready,
    output logic        busy,
    output logic        frame_done
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int RW = $clog2(FRAME_WORDS + 1);

    typedef enum logic [1:0] {IDLE, CHECK, ISSUE, DRAIN} state_t;

    state_t        state;
    logic [29:0]   next_addr;
    logic [RW-1:0] remaining;
    logic [RW-1:0] popped;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] fifo_count;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [31:0]   fifo_mem [FIFO_DEPTH];

    logic [7:0]    len;
    logic [CW-1:0] credit;
    logic          accept;
    logic          fifo_wr;
    logic          fifo_rd;

    // Credit = space not yet spoken for by data already in flight.
    always_comb begin
        len = 8'(remaining);
        if (32'(remaining) >= 32'(BURST_LEN))
            len = 8'(BURST_LEN);
    end

    assign credit    = CW'(FIFO_DEPTH) - fifo_count - outstanding;
    assign accept    = (state == ISSUE) && ddr_read && !ddr_waitrequest;
    assign fifo_wr   = ddr_readdatavalid && (fifo_count != CW'(FIFO_DEPTH));
    assign fifo_rd   = pix_valid && pix_ready;
    assign pix_valid = (fifo_count != '0);
    assign pix_data  = fifo_mem[rd_ptr];

    always_ff @(posedge clk_clk) begin
        if (fifo_wr)
            fifo_mem[wr_ptr] <= ddr_readdata;
    end

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            fifo_count  <= '0;
            outstanding <= '0;
        end else begin
            if (fifo_wr)
                wr_ptr <= wr_ptr + 1'b1;
            if (fifo_rd)
                rd_ptr <= rd_ptr + 1'b1;
            fifo_count  <= fifo_count + CW'(fifo_wr) - CW'(fifo_rd);
            outstanding <= outstanding
                           + (accept ? CW'(ddr_burstcount) : CW'(0))
                           - (ddr_readdatavalid ? CW'(1) : CW'(0));
        end
    end

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            state          <= IDLE;
            ddr_read       <= 1'b0;
            ddr_address    <= '0;
            ddr_burstcount <= '0;
            busy           <= 1'b0;
            frame_done     <= 1'b0;
            next_addr      <= '0;
            remaining      <= '0;
            popped         <= '0;
        end else begin
            frame_done <= 1'b0;
            if (fifo_rd)
                popped <= popped + RW'(1);
            case (state)
                IDLE: begin
                    if (frame_start) begin
                        next_addr <= start_address;
                        remaining <= RW'(FRAME_WORDS);
                        popped    <= '0;
                        busy      <= 1'b1;
                        state     <= CHECK;
                    end
                end
                CHECK: begin
                    if (32'(credit) >= 32'(len)) begin
                        ddr_address    <= next_addr;
                        ddr_burstcount <= len;
                        ddr_read       <= 1'b1;
                        state          <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (accept) begin
                        ddr_read  <= 1'b0;
                        next_addr <= next_addr + {20'd0, ddr_burstcount, 2'b00};
                        remaining <= remaining - RW'(ddr_burstcount);
                        state     <= (remaining == RW'(ddr_burstcount)) ? DRAIN : CHECK;
                    end
                end
                DRAIN: begin
                    if (outstanding == '0 && fifo_count == '0 && popped == RW'(FRAME_WORDS)) begin
                        frame_done <= 1'b1;
                        busy       <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/fb_burst_reader.md
FB_BURST_READER -- requirements
Module: fb_burst_reader

Interface
REQ-001 SHALL have parameter BURST_LEN, default 64: words per full DDR read burst (1..128).
REQ-002 SHALL have parameter FIFO_DEPTH, default 512: internal pixel FIFO depth in words, power of two, at least 2*BURST_LEN.
REQ-003 SHALL have parameter FRAME_WORDS, default 384000: 32-bit words per frame (800x480, 32 bpp).
REQ-004 clk_clk  in  1  single clock for all logic; Avalon master and pixel side share it.
REQ-005 reset_reset  in  1  reset, asynchronous, active-high.
REQ-006 start_address  in  30  frame base byte address, word-aligned (bits [1:0] = 0).
REQ-007 frame_start  in  1  one-cycle pulse that begins fetching a frame.
REQ-008 ddr_address  out  30  Avalon burst byte address.
REQ-009 ddr_burstcount  out  8  Avalon burst length in words.
REQ-010 ddr_read  out  1  Avalon read command.
REQ-011 ddr_waitrequest  in  1  Avalon stall; command accepted when ddr_read=1 and ddr_waitrequest=0.
REQ-012 ddr_readdata  in  32  Avalon read data.
REQ-013 ddr_readdatavalid  in  1  ddr_readdata valid this cycle.
REQ-014 pix_data  out  32  pixel word, head of FIFO (show-ahead).
REQ-015 pix_valid  out  1  FIFO not empty.
REQ-016 pix_ready  in  1  consumer pops the word when pix_valid=1 and pix_ready=1.
REQ-017 busy  out  1  frame in progress, from frame_start acceptance until frame_done.
REQ-018 frame_done  out  1  one-cycle pulse when the last word of the frame is popped.

Function
REQ-019 States SHALL be IDLE, CHECK, ISSUE, DRAIN.
REQ-020 In IDLE, frame_start SHALL latch start_address into the next-address register, load remaining=FRAME_WORDS, set busy, and enter CHECK on the next cycle.
REQ-021 frame_start SHALL be ignored in any state other than IDLE.
REQ-022 CHECK SHALL compute len=min(BURST_LEN, remaining).
REQ-023 CHECK SHALL enter ISSUE only when FIFO free words minus outstanding words is at least len; otherwise it SHALL stay in CHECK.
REQ-024 Outstanding SHALL count words requested but not yet returned; it SHALL be incremented by len on acceptance and decremented by 1 on each ddr_readdatavalid, with both applied in the same cycle when they coincide.
REQ-025 In ISSUE, ddr_read=1 and ddr_address/ddr_burstcount SHALL hold constant until accepted.
REQ-026 On acceptance: address += 4*len, remaining -= len, ddr_read=0 in the next cycle; next state is CHECK if remaining>0, else DRAIN.
REQ-027 One command SHALL be in ISSUE at a time; new bursts may be issued while earlier bursts are still returning data.
REQ-028 Each ddr_readdatavalid word SHALL be written to the FIFO in the same cycle; the credit rule guarantees no overflow, and a write to a full FIFO SHALL not occur.
REQ-029 The final burst SHALL be shortened to the remaining word count (384000 mod 64 = 0; FRAME_WORDS=100, BURST_LEN=64 gives 64 then 36).
REQ-030 DRAIN SHALL wait for outstanding=0, FIFO empty, and popped=FRAME_WORDS, then pulse frame_done, clear busy, and enter IDLE.
REQ-031 A FIFO write and pop in the same cycle SHALL leave the count unchanged, including when the FIFO is empty, where the written word becomes the head one cycle later.
REQ-032 Address arithmetic SHALL wrap modulo 2^30 without error.
REQ-033 pix_valid SHALL drop in the cycle after the last word is popped; the word returned by the first readdatavalid SHALL appear on pix_data no later than the next cycle.

Reset
REQ-034 On reset_reset=1, asynchronously: state=IDLE; ddr_read=0; ddr_address=0; ddr_burstcount=0; busy=0; frame_done=0; pix_valid=0; FIFO, outstanding and remaining counters cleared.
REQ-035 Reset mid-frame SHALL abandon the frame; the Avalon interconnect SHALL be reset by the same signal, so no stale readdatavalid follows.

Verification
REQ-036 start_address=0x100, FRAME_WORDS=128, BURST_LEN=64, no stalls, pix_ready=1 -> two bursts at 0x100 and 0x200, burstcount=64, 128 words in order, one frame_done pulse.
REQ-037 ddr_waitrequest=1 for 5 cycles in ISSUE -> address, burstcount and read stable for all 5 cycles, one acceptance only.
REQ-038 pix_ready=0 throughout, FIFO_DEPTH=128 -> exactly 2 bursts issued, then CHECK stalls with 128 words buffered; releasing pix_ready resumes fetching.
REQ-039 FRAME_WORDS=100 -> bursts of 64 and 36, second address = base+256, frame_done after the 100th pop.
REQ-040 frame_start pulsed while busy, and reset asserted mid-burst -> frame_start ignored; on reset all outputs at reset values within the same cycle; a later frame_start restarts cleanly.
